// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command frame and optionally captures a 48/136-bit response.
// Define SD_CMD_LONG_RESP_EN to enable 136-bit R2 receive; otherwise type 10 is handled as type 01.
module sd_cmd_engine #(
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  output logic         resp_valid_o,
  output logic [5:0]   resp_index_o,
  output logic [119:0] resp_o,
  output logic         err_timeout_o,
  output logic         err_crc_o,
  output logic         err_end_o,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  input  logic         cmd_i
);
  localparam int CNT_MAX = (NCR_MAX > 136) ? NCR_MAX : 136;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef SD_CMD_LONG_RESP_EN
  localparam int RX_W   = 136;
  localparam int RESP_W = 120;
`else
  localparam int RX_W   = 48;
  localparam int RESP_W = 32;
`endif

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE, S_GAP} state_e;
  state_e state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        type_q;
  logic [1:0]        type_eff;
  logic [39:0]       tx_sr;
  logic [6:0]        tx_crc;
  logic [6:0]        rx_crc;
  logic [RX_W-1:0]   rx_sr;
  logic [RX_W-1:0]   rx_frame;
  logic [RESP_W-1:0] resp_q;
  logic              long_q;
  logic              rx_last;
  logic              rx_crc_en;
  logic              tx_bit;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

`ifdef SD_CMD_LONG_RESP_EN
  assign type_eff = resp_type_i;
  assign long_q   = (type_q == 2'b10);
  assign resp_o   = resp_q;
`else
  assign type_eff = (resp_type_i == 2'b10) ? 2'b01 : resp_type_i;
  assign long_q   = 1'b0;
  assign resp_o   = {88'b0, resp_q};
`endif

  assign rx_frame = {rx_sr[RX_W-2:0], cmd_i};
  assign rx_last  = (state == S_RX) && (cnt == (long_q ? CNT_W'(135) : CNT_W'(47)));
  // R2 CRC skips the 8 leading reserved bits; 48b CRC covers the first 40 bits
  assign rx_crc_en = long_q ? ((cnt >= CNT_W'(8)) && (cnt < CNT_W'(128))) : (cnt < CNT_W'(40));
  assign tx_bit    = (cnt < CNT_W'(40)) ? tx_sr[39] :
                     (cnt < CNT_W'(47)) ? tx_crc[6] : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_ready_o  = 1'b0;
    cmd_oe_o     = 1'b0;
    cmd_o        = 1'b1;
    resp_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = S_TX;
      end
      S_TX: begin
        cmd_oe_o = 1'b1;
        cmd_o    = tx_bit;
        if (cnt == CNT_W'(47)) state_nxt = (type_q == 2'b00) ? S_GAP : S_WAIT;
      end
      S_WAIT: begin
        if (!cmd_i)                          state_nxt = S_RX;
        else if (cnt == CNT_W'(NCR_MAX))     state_nxt = S_DONE;
      end
      S_RX: begin
        if (rx_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        state_nxt    = S_GAP;
      end
      S_GAP: begin
        resp_valid_o = (cnt == CNT_W'(1)) && (type_q == 2'b00);
        if (cnt >= CNT_W'(NCC_MIN)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt           <= '0;
      type_q        <= 2'b00;
      resp_q        <= '0;
      resp_index_o  <= '0;
      err_timeout_o <= 1'b0;
      err_crc_o     <= 1'b0;
      err_end_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cnt           <= '0;
            type_q        <= type_eff;
            tx_sr         <= {2'b01, cmd_index_i, cmd_arg_i};
            tx_crc        <= '0;
            resp_q        <= '0;
            resp_index_o  <= '0;
            err_timeout_o <= 1'b0;
            err_crc_o     <= 1'b0;
            err_end_o     <= 1'b0;
          end
        end
        S_TX: begin
          if (cnt < CNT_W'(40)) begin
            tx_sr  <= {tx_sr[38:0], 1'b0};
            tx_crc <= crc7_step(tx_crc, tx_sr[39]);
          end else begin
            tx_crc <= {tx_crc[5:0], 1'b0};
          end
          cnt <= (cnt == CNT_W'(47)) ? CNT_W'(1) : cnt + CNT_W'(1);
        end
        S_WAIT: begin
          if (!cmd_i) begin
            rx_sr  <= '0;
            rx_crc <= '0;
            cnt    <= CNT_W'(1);
          end else if (cnt == CNT_W'(NCR_MAX)) begin
            err_timeout_o <= 1'b1;
            cnt           <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RX: begin
          rx_sr <= rx_frame;
          if (rx_crc_en) rx_crc <= crc7_step(rx_crc, cmd_i);
          cnt <= rx_last ? CNT_W'(1) : cnt + CNT_W'(1);
          if (rx_last) begin
`ifdef SD_CMD_LONG_RESP_EN
            if (long_q) begin
              resp_index_o <= 6'h3F;
              resp_q       <= rx_frame[127:8];
              err_end_o    <= ~rx_frame[0];
              err_crc_o    <= (rx_crc != rx_frame[7:1]);
            end else
`endif
            begin
              resp_index_o <= rx_frame[45:40];
              resp_q       <= RESP_W'(rx_frame[39:8]);
              err_end_o    <= rx_frame[46] | ~rx_frame[0];
              err_crc_o    <= (type_q == 2'b01) && (rx_crc != rx_frame[7:1]);
            end
          end
        end
        S_DONE, S_GAP: cnt <= cnt + CNT_W'(1);
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: scoreboards for the driven CMD frame and the response pulse.
module tb_sd_cmd_engine;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [5:0]   cmd_index_i = '0;
  logic [31:0]  cmd_arg_i = '0;
  logic [1:0]   resp_type_i = '0;
  logic         resp_valid_o;
  logic [5:0]   resp_index_o;
  logic [119:0] resp_o;
  logic         err_timeout_o, err_crc_o, err_end_o;
  logic         cmd_o, cmd_oe_o;
  logic         cmd_i = 1'b1;

  sd_cmd_engine #(.NCR_MAX(64), .NCC_MIN(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i),
    .resp_valid_o(resp_valid_o), .resp_index_o(resp_index_o), .resp_o(resp_o),
    .err_timeout_o(err_timeout_o), .err_crc_o(err_crc_o), .err_end_o(err_end_o),
    .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .cmd_i(cmd_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [5:0]   idx;
    logic [119:0] resp;
    logic         to;
    logic         crc;
    logic         en;
  } exp_t;

  exp_t        rxq[$];
  logic [47:0] txq[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: collects every driven 48-bit frame; partial frames (reset) are dropped
  logic [47:0] txf = '0;
  int          txn = 0;
  always @(negedge clk_i) begin
    if (cmd_oe_o) begin
      txf = {txf[46:0], cmd_o};
      txn++;
      if (txn == 48) begin
        if (txq.size() == 0) chk("unexpected_frame", {80'b0, txf}, 128'h0);
        else chk("tx_frame", {80'b0, txf}, {80'b0, txq.pop_front()});
        txn = 0;
      end
    end else begin
      txn = 0;
    end
  end

  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (rxq.size() == 0) begin
        chk("unexpected_resp_valid", 128'h1, 128'h0);
      end else begin
        exp_t e;
        e = rxq.pop_front();
        chk("resp_index", {122'b0, resp_index_o}, {122'b0, e.idx});
        chk("resp_data", {8'b0, resp_o}, {8'b0, e.resp});
        chk("err_timeout", {127'b0, err_timeout_o}, {127'b0, e.to});
        chk("err_crc", {127'b0, err_crc_o}, {127'b0, e.crc});
        chk("err_end", {127'b0, err_end_o}, {127'b0, e.en});
      end
    end
  end

  // Cycle 0 is the accept cycle; the card's start bit lands in cycle 48+card_dly
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                         input logic [47:0] exp_frame, input logic card_en,
                         input logic [135:0] card_frame, input int card_len, input int card_dly,
                         input exp_t exp, input int exp_resp_cyc, input int exp_ready_cyc);
    int cyc, resp_cyc, ready_cyc, guard;
    guard = 0;
    while (!cmd_ready_o && guard < 300) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("ready_before_issue", {127'b0, cmd_ready_o}, 128'h1);
    txq.push_back(exp_frame);
    rxq.push_back(exp);
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    resp_type_i = rtype;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    cyc = 1; resp_cyc = 0; ready_cyc = 0;
    chk("ready_drop", {127'b0, cmd_ready_o}, 128'h0);
    chk("err_clear_on_accept", {125'b0, err_timeout_o, err_crc_o, err_end_o}, 128'h0);
    while (ready_cyc == 0 && cyc < 400) begin
      if (card_en && cyc >= 48 + card_dly && cyc < 48 + card_dly + card_len)
        cmd_i = card_frame[card_len - 1 - (cyc - 48 - card_dly)];
      else
        cmd_i = 1'b1;
      if (resp_valid_o && resp_cyc == 0) resp_cyc = cyc;
      if (cmd_ready_o) ready_cyc = cyc;
      else begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    cmd_i = 1'b1;
    chk("txn_complete", {127'b0, ready_cyc != 0}, 128'h1);
    if (exp_resp_cyc != 0) chk("resp_cycle", 128'(resp_cyc), 128'(exp_resp_cyc));
    if (exp_ready_cyc != 0) chk("ready_cycle", 128'(ready_cyc), 128'(exp_ready_cyc));
  endtask

`ifdef SD_CMD_LONG_RESP_EN
  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
`endif

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [119:0] cid_body;
    logic [135:0] r2;
    exp_t e;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", {127'b0, cmd_ready_o}, 128'h1);
    chk("rst_cmd", {127'b0, cmd_o}, 128'h1);
    chk("rst_oe", {127'b0, cmd_oe_o}, 128'h0);
    chk("rst_resp_valid", {127'b0, resp_valid_o}, 128'h0);
    chk("rst_errs", {125'b0, err_timeout_o, err_crc_o, err_end_o}, 128'h0);
    chk("rst_resp", {8'b0, resp_o}, 128'h0);
    chk("rst_index", {122'b0, resp_index_o}, 128'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // CMD0, no response
    run_txn(6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, 1'b0, '0, 48, 0,
            '{idx: 6'h0, resp: '0, to: 1'b0, crc: 1'b0, en: 1'b0}, 49, 57);
    // CMD8 with good R7
    run_txn(6'd8, 32'h1AA, 2'b01, 48'h48_0000_01AA_87, 1'b1, {88'b0, 48'h08_0000_01AA_13}, 48, 2,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b0, en: 1'b0}, 98, 0);
    // CRC field 0x14: CRC wrong and end bit 0
    run_txn(6'd8, 32'h1AA, 2'b01, 48'h48_0000_01AA_87, 1'b1, {88'b0, 48'h08_0000_01AA_14}, 48, 5,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b1, en: 1'b1}, 0, 0);
    chk("err_crc_hold", {127'b0, err_crc_o}, 128'h1);
    chk("err_end_hold", {127'b0, err_end_o}, 128'h1);
    // Good CRC, end bit 0
    run_txn(6'd8, 32'h1AA, 2'b01, 48'h48_0000_01AA_87, 1'b1, {88'b0, 48'h08_0000_01AA_12}, 48, 1,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b0, en: 1'b1}, 97, 0);
    // CMD17, card silent
    run_txn(6'd17, 32'h0, 2'b01, 48'h51_0000_0000_55, 1'b0, '0, 48, 0,
            '{idx: 6'h0, resp: '0, to: 1'b1, crc: 1'b0, en: 1'b0}, 113, 0);
    // CMD17, start bit on the last allowed cycle
    run_txn(6'd17, 32'h0, 2'b01, 48'h51_0000_0000_55, 1'b1, {88'b0, 48'h08_0000_01AA_13}, 48, 64,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b0, en: 1'b0}, 160, 0);
    // Type 11 ignores a bad CRC
    run_txn(6'd8, 32'h1AA, 2'b11, 48'h48_0000_01AA_87, 1'b1, {88'b0, 48'h08_0000_01AA_15}, 48, 3,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b0, en: 1'b0}, 0, 0);
`ifdef SD_CMD_LONG_RESP_EN
    cid_body = 120'h0353_4453_5533_3247_8012_3456_7801_4E;
    r2 = {8'h3F, cid_body, crc7_120(cid_body), 1'b1};
    run_txn(6'd2, 32'h0, 2'b10, 48'h42_0000_0000_4D, 1'b1, r2, 136, 2,
            '{idx: 6'h3F, resp: cid_body, to: 1'b0, crc: 1'b0, en: 1'b0}, 0, 0);
`else
    cid_body = '0;
    r2 = '0;
    run_txn(6'd2, 32'h0, 2'b10, 48'h42_0000_0000_4D, 1'b1, {88'b0, 48'h08_0000_01AA_14}, 48, 2,
            '{idx: 6'd8, resp: 120'h1AA, to: 1'b0, crc: 1'b1, en: 1'b1}, 0, 0);
`endif
    e = '{idx: 6'h0, resp: '0, to: 1'b0, crc: 1'b0, en: 1'b0};

    // Reset during TX cycle 20
    cmd_index_i = 6'd0; cmd_arg_i = 32'h0; resp_type_i = 2'b00;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    repeat (19) begin @(posedge clk_i); #1; end
    chk("mid_tx_oe", {127'b0, cmd_oe_o}, 128'h1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_oe", {127'b0, cmd_oe_o}, 128'h0);
    chk("abort_ready", {127'b0, cmd_ready_o}, 128'h1);
    chk("abort_cmd", {127'b0, cmd_o}, 128'h1);
    repeat (80) begin @(posedge clk_i); #1; end
    run_txn(6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, 1'b0, '0, 48, 0, e, 49, 57);

    repeat (4) begin @(posedge clk_i); #1; end
    chk("tx_queue_empty", 128'(txq.size()), 128'h0);
    chk("resp_queue_empty", 128'(rxq.size()), 128'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
